// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bus for serial_subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;

   modport master (output start, a, b, b_in, input busy, done, diff, b_out);
   modport slave  (input start, a, b, b_in, output busy, done, diff, b_out);
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - b_in, LSB first, one bit per clock
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] diff_q;
   logic             b_out_q;
   logic             borrow, borrow_next;
   logic [CW-1:0]    cnt;
   logic             d, load, step, last;

   assign d           = a_sr[0] ^ b_sr[0] ^ borrow;
   assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
   // res_sr keeps only the upper WIDTH-1 bits; the incoming bit completes the word
   assign res_next    = {d, res_sr};
   assign last        = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else if (load) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         borrow <= bus.b_in;
         res_sr <= '0;
         cnt    <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         borrow <= borrow_next;
         res_sr <= res_next[WIDTH-1:1];
         cnt    <= cnt + 1'b1;
         if (last) begin
            diff_q  <= res_next;
            b_out_q <= borrow_next;
         end
      end
   end

   assign bus.busy  = (state == SHIFT);
   assign bus.done  = (state == DONE);
   assign bus.diff  = diff_q;
   assign bus.b_out = b_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [WIDTH:0] sb[$];

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
   serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
      return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
   endfunction

   // every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) check("spurious_done", 1, 0);
         else check("result", {23'd0, bus.b_out, bus.diff}, {23'd0, sb.pop_front()});
      end
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi, input bit expect_result);
      bus.a = a; bus.b = b; bus.b_in = bi; bus.start = 1'b1;
      if (expect_result) sb.push_back(model(a, b, bi));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.b_in = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
      check(tag, bus.done, 1);
      @(negedge clk);
   endtask

   initial begin
      int ndone;
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_bout", bus.b_out, 0);
      rst = 1'b0;
      @(negedge clk);

      issue(8'd22, 8'd33, 1'b0, 1);
      for (int i = 0; i < WIDTH; i++) begin
         check("t1_busy", bus.busy, 1);
         check("t1_nodone", bus.done, 0);
         @(negedge clk);
      end
      check("t1_done", bus.done, 1);
      check("t1_busy_low", bus.busy, 0);
      check("t1_diff", bus.diff, 245);
      check("t1_bout", bus.b_out, 1);
      @(negedge clk);
      check("t1_done_pulse", bus.done, 0);

      issue(8'd112, 8'd34, 1'b1, 1); wait_done("t2_wait");
      issue(8'd0, 8'd0, 1'b1, 1);    wait_done("t3_wait");
      check("wrap_diff", bus.diff, 255);
      issue(8'd128, 8'd128, 1'b0, 1); wait_done("t4_wait");
      check("eq_diff", bus.diff, 0);

      issue(8'd123, 8'd54, 1'b0, 1);
      @(negedge clk);
      issue(8'd1, 8'd2, 1'b0, 0);
      wait_done("ign_wait");
      check("ign_diff", bus.diff, 69);
      repeat (12) @(negedge clk);

      issue(8'd255, 8'd0, 1'b0, 1);
      for (int i = 0; i < WIDTH; i++) begin
         check("hold_diff", bus.diff, 69);
         @(negedge clk);
      end
      check("hold_done", bus.done, 1);
      check("hold_new_diff", bus.diff, 255);
      check("hold_new_bout", bus.b_out, 0);
      @(negedge clk);

      bus.a = 8'd91; bus.b = 8'd11; bus.b_in = 1'b1; bus.start = 1'b1;
      repeat (3) sb.push_back(model(8'd91, 8'd11, 1'b1));
      ndone = 0;
      for (int cyc = 1; cyc <= 40 && ndone < 3; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            check("b2b_period", cyc, 9 * ndone);
            check("b2b_busy_low", bus.busy, 0);
            if (ndone == 3) bus.start = 1'b0;
         end else begin
            check("b2b_busy", bus.busy, 1);
         end
      end
      bus.start = 1'b0;
      check("b2b_count", ndone, 3);
      @(negedge clk);

      issue(8'd200, 8'd1, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_diff", bus.diff, 0);
      check("mid_rst_bout", bus.b_out, 0);
      repeat (15) @(negedge clk);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
